// File: rtl/rlwe_mem_pkg.sv
// Shared definitions for the RLWE data-memory initiator.
// Provides the SCR1-style memory interface types (command, width, response),
// the RLWE vector type and stride, and the initiator FSM state encoding.
package rlwe_mem_pkg;

    // Data-memory address width of the host core.
    localparam int SCR1_DMEM_AWIDTH = 32;

    // One vector is LANE 32-bit words; consecutive vectors are 4*LANE bytes apart.
    localparam int LANE       = 4;
    localparam int RLWE_VEC_W = 32 * LANE;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] RLWE_VEC_STRIDE = SCR1_DMEM_AWIDTH'(4 * LANE);

    typedef logic [RLWE_VEC_W-1:0] type_vector;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [2:0] {
        SCR1_MEM_WIDTH_BYTE  = 3'd0,
        SCR1_MEM_WIDTH_HWORD = 3'd1,
        SCR1_MEM_WIDTH_WORD  = 3'd2,
        SCR1_MEM_WIDTH_VEC   = 3'd4,
        SCR1_MEM_WIDTH_ERROR = 3'd7
    } type_scr1_mem_width_e;

    // Every transfer issued by the initiator moves one whole vector.
    localparam type_scr1_mem_width_e RLWE_MEM_WIDTH_VEC = SCR1_MEM_WIDTH_VEC;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } rlwe_dmem_state_e;

endpackage

// File: rtl/rlwe_vec_fifo2.sv
// Two-entry, vector-wide FIFO holding read data on its way to the RLWE core.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drop all entries (wins over push/pop)
//   push, push_data  write one vector (ignored when full and not popping)
//   pop, pop_data    remove the head entry (ignored when empty); pop_data is the head
//   count, empty     current occupancy (0..2) and its empty flag
module rlwe_vec_fifo2
    import rlwe_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  type_vector push_data,
    input  logic       pop,
    output type_vector pop_data,
    output logic [1:0] count,
    output logic       empty
);

    type_vector mem [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/rlwe_dmem_initiator.sv
// Moves a job of vec_cnt vectors between the RLWE core and the TCM over an
// SCR1-style data-memory port, one request outstanding at a time.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, dir, base_addr, vec_cnt job launch (dir 0 = read TCM, 1 = write TCM)
//   busy, done, err                job status; done/err are one-cycle pulses
//   wr_vdata/wr_valid/wr_ready     write-data stream from the core
//   rd_vdata/rd_valid/rd_ready     read-data stream to the core
//   dmem_*                         memory request/response port
module rlwe_dmem_initiator
    import rlwe_mem_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        dir,
    input  logic [SCR1_DMEM_AWIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]            vec_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  type_vector                  wr_vdata,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output type_vector                  rd_vdata,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic                        dmem_req,
    output type_scr1_mem_cmd_e          dmem_cmd,
    output type_scr1_mem_width_e        dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    output type_vector                  dmem_wdata,
    input  logic                        dmem_req_ack,
    input  type_vector                  dmem_rdata,
    input  type_scr1_mem_resp_e         dmem_resp
);

    rlwe_dmem_state_e              state_q, state_d;
    logic                          dir_q;
    logic [SCR1_DMEM_AWIDTH-1:0]   addr_q;       // address of the next request
    logic [CNT_W-1:0]              issue_cnt_q;  // requests still to be accepted
    logic [CNT_W-1:0]              resp_cnt_q;   // responses still to be received
    logic                          outst_q;      // one request accepted, response pending
    logic                          hold_q;       // request shown but not yet acked
    type_vector                    wdata_q;
    logic                          err_q;

    logic       resp_ok;
    logic       resp_er;
    logic       new_req;
    logic       accept;
    logic       pop;
    logic [2:0] rd_occ;
    logic [1:0] fifo_count;
    logic       fifo_empty;

    // Responses only count while a request is outstanding; anything else
    // (e.g. a late response after reset) is ignored.
    assign resp_ok = outst_q && (dmem_resp == SCR1_MEM_RESP_RDY_OK);
    assign resp_er = outst_q && (dmem_resp == SCR1_MEM_RESP_RDY_ER);
    assign pop     = rd_valid && rd_ready;
    // Read buffer demand: entries held, minus the one leaving, plus the one in
    // flight. A new read is allowed only if that leaves a free slot for it.
    assign rd_occ  = {1'b0, fifo_count} + {2'b00, outst_q} - {2'b00, pop};

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        new_req    = 1'b0;
        dmem_cmd   = dir_q ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem_width = RLWE_MEM_WIDTH_VEC;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;

        // A new request needs a free slot (nothing outstanding, or the
        // outstanding one completing right now) and a data source/sink.
        if ((state_q == ST_RUN) && !hold_q && (issue_cnt_q != '0) &&
            (!outst_q || resp_ok) &&
            (dir_q ? wr_valid : (rd_occ <= 3'd1))) begin
            new_req = 1'b1;
        end
        dmem_req = hold_q || new_req;
        if (new_req && dir_q) dmem_wdata = wr_vdata;
        accept   = dmem_req && dmem_req_ack;

        case (state_q)
            ST_IDLE:  if (start) state_d = (vec_cnt == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && (issue_cnt_q == CNT_W'(1))) state_d = ST_WAIT;
            ST_WAIT:  if (resp_ok && (resp_cnt_q == CNT_W'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (resp_er) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            outst_q     <= 1'b0;
            hold_q      <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= resp_er;
            hold_q  <= dmem_req && !dmem_req_ack;

            if ((state_q == ST_IDLE) && start) begin
                dir_q       <= dir;
                addr_q      <= base_addr;
                issue_cnt_q <= vec_cnt;
                resp_cnt_q  <= vec_cnt;
            end

            // Latch write data at issue so a stalled request keeps it stable.
            if (new_req && dir_q) wdata_q <= wr_vdata;

            if (accept) begin
                addr_q      <= addr_q + RLWE_VEC_STRIDE;
                issue_cnt_q <= issue_cnt_q - CNT_W'(1);
                outst_q     <= 1'b1;
            end else if (resp_ok || resp_er) begin
                outst_q <= 1'b0;
            end

            if (resp_ok) resp_cnt_q <= resp_cnt_q - CNT_W'(1);

            if (resp_er) begin
                issue_cnt_q <= '0;
                resp_cnt_q  <= '0;
            end
        end
    end

    rlwe_vec_fifo2 u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (resp_er),
        .push      (resp_ok && !dir_q),
        .push_data (dmem_rdata),
        .pop       (pop),
        .pop_data  (rd_vdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign wr_ready = accept && dir_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DRAIN) && fifo_empty;
    assign err      = err_q;

endmodule

// File: tb/tb_rlwe_dmem_initiator.sv
module tb_rlwe_dmem_initiator;
    import rlwe_mem_pkg::*;

    localparam int CNT_W = 16;
    localparam int AW    = SCR1_DMEM_AWIDTH;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 dir;
    logic [AW-1:0]        base_addr;
    logic [CNT_W-1:0]     vec_cnt;
    logic                 busy;
    logic                 done;
    logic                 err;
    type_vector           wr_vdata;
    logic                 wr_valid;
    logic                 wr_ready;
    type_vector           rd_vdata;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [AW-1:0]        dmem_addr;
    type_vector           dmem_wdata;
    logic                 dmem_req_ack;
    type_vector           dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    rlwe_dmem_initiator #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dir          (dir),
        .base_addr    (base_addr),
        .vec_cnt      (vec_cnt),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .wr_vdata     (wr_vdata),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_vdata     (rd_vdata),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One job: stimulus knobs plus the expected job-level outcome.
    typedef struct {
        bit          dir;
        logic [31:0] base;
        int          cnt;
        int          rd_hold;      // leading cycles with rd_ready low
        bit          rd_rand;      // afterwards rd_ready random (else 1)
        bit          ack_rand;
        int          notrdy_max;   // NOTRDY cycles before a response
        bit          fixed_delay;  // use notrdy_max exactly
        int          wr_mode;      // 0 always valid, 1 toggle, 2 random
        int          err_at;       // response index returning RDY_ER, -1 none
        bit          restart;      // pulse a stray start mid-job
        int          exp_reqs;
        int          exp_beats;
        int          exp_done;
        int          exp_err;
    } job_t;

    int n_checks = 0;
    int n_err    = 0;

    // Memory model and recorded observations.
    int          cyc;
    bit          pend;
    type_vector  pend_data;
    int          pend_delay;
    int          resp_idx;
    logic [31:0] salt;
    logic [31:0] req_addr[$];
    int          req_cyc[$];
    type_vector  beats[$];
    type_vector  wq[$];
    type_vector  wexp[$];
    int          done_cnt, err_cnt, done_cyc, err_cyc, er_cyc, wrr_cnt;
    bit          prev_stall;
    logic [31:0] prev_addr;
    type_vector  prev_wdata;
    logic        prev_cmd;
    logic        last_busy, last_rd_valid;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic type_vector mem_word(input logic [31:0] a);
        return {a, ~a, a ^ salt, salt};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        logic [31:0] off;
        off = 32'(k) * RLWE_VEC_STRIDE;
        return base + off;
    endfunction

    function automatic job_t mk_job(input bit d, input logic [31:0] b, input int c,
                                    input int hold, input bit rr, input bit ar,
                                    input int nr, input int wm, input int ea,
                                    input bit rs, input int er, input int eb,
                                    input int ed, input int ee);
        job_t j;
        j.dir = d; j.base = b; j.cnt = c; j.rd_hold = hold; j.rd_rand = rr;
        j.ack_rand = ar; j.notrdy_max = nr; j.fixed_delay = 1'b0; j.wr_mode = wm;
        j.err_at = ea; j.restart = rs; j.exp_reqs = er; j.exp_beats = eb;
        j.exp_done = ed; j.exp_err = ee;
        return j;
    endfunction

    task automatic prep_job(input job_t j);
        req_addr.delete(); req_cyc.delete(); beats.delete(); wq.delete(); wexp.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; er_cyc = -1; wrr_cnt = 0;
        pend = 1'b0; resp_idx = 0; prev_stall = 1'b0; salt = $urandom;
        if (j.dir) begin
            for (int i = 0; i < j.cnt; i++) begin
                type_vector v;
                v = {$urandom, $urandom, $urandom, $urandom};
                wq.push_back(v);
                wexp.push_back(v);
            end
        end
    endtask

    // Called just after a falling edge: drives inputs, samples the settled
    // outputs, updates the model, and returns at the next falling edge.
    task automatic do_cycle(input job_t j);
        rd_ready     = (cyc < j.rd_hold) ? 1'b0 : (j.rd_rand ? 1'($urandom % 2) : 1'b1);
        dmem_req_ack = j.ack_rand ? ($urandom % 3 != 0) : 1'b1;
        case (j.wr_mode)
            0:       wr_valid = (wq.size() > 0);
            1:       wr_valid = (wq.size() > 0) && (cyc % 2 == 1);
            default: wr_valid = (wq.size() > 0) && ($urandom % 2 == 1);
        endcase
        wr_vdata = (wq.size() > 0) ? wq[0] : {$urandom, $urandom, $urandom, $urandom};
        if (pend && pend_delay == 0) begin
            dmem_resp  = (resp_idx == j.err_at) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            dmem_rdata = pend_data;
        end else begin
            dmem_resp  = SCR1_MEM_RESP_NOTRDY;
            dmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (pend) pend_delay--;
        end
        #1;
        if (dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
            if (dmem_resp == SCR1_MEM_RESP_RDY_ER) er_cyc = cyc;
            pend = 1'b0;
            resp_idx++;
        end
        if (prev_stall) begin
            check("req_held", dmem_req, 1'b1);
            check("req_held_addr", dmem_addr, prev_addr);
            check("req_held_cmd", dmem_cmd, prev_cmd);
            check("req_held_wdata", dmem_wdata, prev_wdata);
        end else if (dmem_req && j.dir) begin
            check("req_needs_wr_valid", wr_valid, 1'b1);
        end
        if (dmem_req && dmem_req_ack) begin
            int k;
            k = req_addr.size();
            check("one_outstanding", pend, 1'b0);
            check("req_cmd", dmem_cmd, j.dir ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
            check("req_width", dmem_width, RLWE_MEM_WIDTH_VEC);
            if (j.dir && k < wexp.size()) check("req_wdata", dmem_wdata, wexp[k]);
            req_addr.push_back(dmem_addr);
            req_cyc.push_back(cyc);
            pend       = 1'b1;
            pend_data  = mem_word(dmem_addr);
            pend_delay = j.fixed_delay ? j.notrdy_max : int'($urandom_range(j.notrdy_max, 0));
        end
        if (wr_ready || (dmem_req && dmem_req_ack && j.dir))
            check("wr_ready_rule", wr_ready, dmem_req && dmem_req_ack && j.dir);
        if (wr_ready) begin
            wrr_cnt++;
            if (wq.size() > 0) void'(wq.pop_front());
        end
        if (rd_valid && rd_ready) beats.push_back(rd_vdata);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
        prev_stall    = dmem_req && !dmem_req_ack;
        prev_addr     = dmem_addr;
        prev_cmd      = dmem_cmd;
        prev_wdata    = dmem_wdata;
        last_busy     = busy;
        last_rd_valid = rd_valid;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_job(input job_t j);
        prep_job(j);
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            start     = (cyc == 0);
            dir       = j.dir;
            base_addr = j.base;
            vec_cnt   = CNT_W'(j.cnt);
            if (j.restart && cyc == 2) begin
                start     = 1'b1;
                dir       = ~j.dir;
                base_addr = $urandom;
                vec_cnt   = CNT_W'($urandom_range(9, 1));
            end
            do_cycle(j);
            if (cyc >= 2 && !last_busy) break;
        end
        start = 1'b0;
        check("job_finished", last_busy, 1'b0);
        check("req_count", req_addr.size(), j.exp_reqs);
        for (int k = 0; k < req_addr.size() && k < j.exp_reqs; k++)
            check("req_addr", req_addr[k], exp_addr(j.base, k));
        check("beat_count", beats.size(), j.exp_beats);
        for (int k = 0; k < beats.size() && k < j.exp_beats; k++)
            check("rd_data", beats[k], mem_word(exp_addr(j.base, k)));
        if (j.dir) check("wr_ready_count", wrr_cnt, j.exp_reqs);
        check("done_count", done_cnt, j.exp_done);
        check("err_count", err_cnt, j.exp_err);
        if (j.exp_err > 0) check("err_timing", err_cyc, er_cyc + 1);
        check("rd_valid_after", last_rd_valid, 1'b0);
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        @(negedge clk);
    endtask

    job_t tbl[8];
    job_t jh;

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; vec_cnt = '0;
        wr_vdata = '0; wr_valid = 1'b0; rd_ready = 1'b0; dmem_req_ack = 1'b0;
        dmem_rdata = '0; dmem_resp = SCR1_MEM_RESP_NOTRDY; cyc = 0;

        tbl[0] = mk_job(0, 32'h0000_1000, 7, 0, 1, 1, 2, 0, -1, 0, 7, 7, 1, 0);
        tbl[1] = mk_job(1, 32'h0000_2000, 5, 0, 0, 1, 2, 2, -1, 0, 5, 0, 1, 0);
        tbl[2] = mk_job(0, $urandom,      5, 0, 0, 0, 0, 0, -1, 1, 5, 5, 1, 0);
        tbl[3] = mk_job(1, 32'h0000_4000, 4, 0, 0, 0, 1, 0, -1, 1, 4, 0, 1, 0);
        tbl[4] = mk_job(0, 32'h0000_5000, 3, 100000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[5] = mk_job(1, 32'h0000_6000, 5, 0, 0, 1, 1, 0, 2, 0, 3, 0, 0, 1);
        tbl[6] = mk_job(1, 32'h0000_7000, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 1, 0);
        tbl[7] = mk_job(0, 32'h0000_8000, 9, 0, 1, 0, 0, 0, -1, 0, 9, 9, 1, 0);

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
        check("rst_addr", dmem_addr, '0);
        check("rst_wdata", dmem_wdata, '0);
        check("rst_rd_valid", rd_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic full-throughput read.
        jh = mk_job(0, 32'h0000_0100, 4, 0, 0, 0, 0, 0, -1, 0, 4, 4, 1, 0);
        run_job(jh);
        for (int k = 0; k < req_cyc.size(); k++) check("rd_back_to_back", req_cyc[k], 1 + k);

        // Consumer stalled for 5 cycles: buffer limits issue to two requests.
        jh = mk_job(0, 32'h0000_0200, 6, 5, 0, 0, 0, 0, -1, 0, 6, 6, 1, 0);
        run_job(jh);
        begin
            int early;
            early = 0;
            foreach (req_cyc[k]) if (req_cyc[k] < 5) early++;
            check("stall_two_reqs", early, 2);
        end

        // Write with wr_valid toggling.
        jh = mk_job(1, 32'h0000_0300, 3, 0, 0, 0, 0, 1, -1, 0, 3, 0, 1, 0);
        run_job(jh);

        // Second read response is an error.
        jh = mk_job(0, 32'h0000_0400, 4, 100000, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
        run_job(jh);

        // Address wrap at the top of the range.
        jh = mk_job(0, 32'hFFFF_FFF0, 2, 0, 0, 0, 0, 0, -1, 0, 2, 2, 1, 0);
        run_job(jh);
        if (req_addr.size() > 1) check("wrap_addr", req_addr[1], 32'h0);

        // Empty job.
        jh = mk_job(0, 32'h0000_0500, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 1, 0);
        run_job(jh);
        check("zero_done_cycle", done_cyc, 1);

        // Randomized table.
        for (int t = 0; t < 8; t++) run_job(tbl[t]);

        // Reset while waiting for a write response.
        jh = mk_job(1, 32'h2000_0040, 1, 0, 0, 0, 50, 0, -1, 0, 0, 0, 0, 0);
        jh.fixed_delay = 1'b1;
        prep_job(jh);
        cyc = 0;
        start = 1'b1; dir = 1'b1; base_addr = jh.base; vec_cnt = CNT_W'(1);
        do_cycle(jh);
        start = 1'b0;
        repeat (3) do_cycle(jh);
        check("pre_reset_busy", busy, 1'b1);
        check("pre_reset_wdata", dmem_wdata, wexp[0]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req", dmem_req, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_wr_ready", wr_ready, 1'b0);
        check("mid_rst_rd_valid", rd_valid, 1'b0);
        check("mid_rst_addr", dmem_addr, '0);
        check("mid_rst_wdata", dmem_wdata, '0);
        check("mid_rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
        @(negedge clk);
        rst_n = 1'b1;
        pend = 1'b0;
        dmem_resp  = SCR1_MEM_RESP_RDY_OK;
        dmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        check("late_resp_busy", busy, 1'b0);
        check("late_resp_rd_valid", rd_valid, 1'b0);
        check("late_resp_err", err, 1'b0);
        @(negedge clk);
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        @(negedge clk);
        jh = mk_job(0, 32'h0000_0900, 3, 0, 0, 0, 1, 0, -1, 0, 3, 3, 1, 0);
        run_job(jh);
        if (req_cyc.size() > 0) check("post_rst_first_req", req_cyc[0], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
